mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
Data-memory access stage between the multicycle controller/datapath and a word-wide, handshaked data memory that has no byte enables.
- Accepts one load or store per request; MemMode selects the store width (word, half or byte).
- Sub-word stores are performed as read-modify-write. Busy and Done let the controller sequence around variable memory latency.
- Load data is returned shifted to the LSB so the downstream extend logic can select width and sign.

Parameters:
ADDR_W, 16, word-address width on the memory side (byte address bits used = ADDR_W+2)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
req_read  input  1  load request, sampled only in IDLE
req_write  input  1  store request (controller MemWrite), sampled only in IDLE
MemMode  input  2  store width: 00 word, 01 half, 10 byte, 11 treated as word
Adr  input  32  byte address
WriteData  input  32  store data, LSB-aligned
ReadData  output  32  loaded word shifted right by 8*Adr[1:0], zero-filled
Busy  output  1  high whenever state != IDLE
Done  output  1  one-cycle completion pulse
Misaligned  output  1  misalignment flag (see Optional Feature)
mem_req  output  1  memory request, held until mem_gnt
mem_we  output  1  1 = write, 0 = read
mem_addr  output  ADDR_W  word address = Adr[ADDR_W+1:2]
mem_wdata  output  32  full word to write
mem_gnt  input  1  request accepted this cycle
mem_rvalid  input  1  read data valid (at least 1 cycle after gnt)
mem_rdata  input  32  read data

Behaviour:
- Reset values: all outputs 0, state IDLE, internal registers 0. Reset mid-operation returns to IDLE immediately and mem_req drops asynchronously. A late mem_rvalid arriving in IDLE is ignored.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE.
- IDLE: on req_write or req_read, latch Adr, WriteData, MemMode and the op.
  - If req_write and req_read are both high, the write is taken and the read is dropped.
  - Next state: WR_REQ for a word store; RD_REQ for a load or a half/byte store.
  - Requests in any other state are ignored, not queued.
- RD_REQ: mem_req=1, mem_we=0. On mem_gnt go to RD_WAIT.
- RD_WAIT: mem_req=0. On mem_rvalid:
  - Load: ReadData <= mem_rdata >> (8*Adr[1:0]), then go to DONE.
  - Sub-word store: merge into the write-data register, then go to WR_REQ.
    - Byte: bits [8k+7:8k] <= WriteData[7:0], with k=Adr[1:0].
    - Half: bits [16h+15:16h] <= WriteData[15:0], with h=Adr[1].
    - All other bits keep mem_rdata.
- WR_REQ: mem_req=1, mem_we=1, mem_wdata = registered word. On mem_gnt go to DONE.
- DONE: Done=1 for exactly one cycle, then IDLE. ReadData holds until the next load completes.
- mem_addr and mem_wdata are driven from registers and are stable while mem_req=1.
- Minimum latency, counted from the accept cycle c0 (gnt same cycle as req, rvalid the cycle after gnt):
  - Word store: Done in c2.
  - Load: Done in c3.
  - Sub-word store: Done in c4.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: at accept, a half access with Adr[0]=1 or a word access with Adr[1:0]!=0 produces no memory transaction. The state goes IDLE→DONE, and Misaligned=1 together with that Done pulse. Misaligned clears on the next accept.
- Undefined: Misaligned is tied 0.
  - Word accesses ignore Adr[1:0].
  - Half stores use Adr[1] only; Adr[0] is ignored.
  - Byte stores are unaffected.
- Loads are checked as word accesses, since MemMode is 00 for loads.

Test Plan:
- Word store: Adr=0x10, WriteData=0xDEADBEEF, gnt immediate → mem_we=1, mem_addr=4, mem_wdata=0xDEADBEEF, Done in c2, Busy high c1–c2.
- Byte store: memory word at addr 4 = 0x11223344; sb 0xAB to Adr=0x12 → read, then write 0x11AB3344, Done once.
- Half store: Adr=0x12, WriteData=0x0000CAFE over 0x11223344 → write 0xCAFE3344. Grant delayed 3 cycles → mem_req held and mem_addr stable throughout.
- Load: Adr=0x13, mem_rdata=0x80FF0102 with rvalid 2 cycles after gnt → ReadData=0x00000080. req_write pulsed while Busy is ignored.
- Reset asserted in RD_WAIT → outputs 0 at once; a following rvalid produces no Done. Simultaneous req_read+req_write → only the write is performed.
- MISALIGN_TRAP_EN: word store to Adr=0x11 → no mem_req, Done with Misaligned=1 in c1. Without the macro → write to mem_addr=4.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: sits between the multicycle datapath and a word-wide,
// handshaked data memory that has no byte enables.
//
// Loads and word stores each take one memory transaction. Half-word and byte
// stores are done as read-modify-write: the word is read, the new lane is
// merged in, and the whole word is written back. Load data is returned
// shifted down so that the addressed byte sits in bits [7:0].
//
// Optional build macro: MISALIGN_TRAP_EN. When it is defined, a misaligned
// word access or half store is not sent to memory. It finishes with Done and
// Misaligned both high. When the macro is undefined, Misaligned is tied low
// and the low address bits that do not apply are ignored.
//
// Ports:
//   clk, reset             clock (rising edge), asynchronous active-high reset
//   req_read, req_write    load / store request, sampled only while idle
//   MemMode                store width: 00 word, 01 half, 10 byte, 11 word
//   Adr, WriteData         byte address and LSB-aligned store data
//   ReadData               loaded word >> 8*Adr[1:0], zero-filled
//   Busy, Done             busy level and one-cycle completion pulse
//   Misaligned             trap flag (tied 0 unless MISALIGN_TRAP_EN)
//   mem_req/we/addr/wdata  memory request side; request held until mem_gnt
//   mem_gnt                request accepted this cycle
//   mem_rvalid, mem_rdata  read response, at least one cycle after the grant

module mem_access_unit #(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [1:0]        MemMode,
  input  logic [31:0]       Adr,
  input  logic [31:0]       WriteData,
  output logic [31:0]       ReadData,
  output logic              Busy,
  output logic              Done,
  output logic              Misaligned,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {
    StIdle,
    StRdReq,
    StRdWait,
    StWrReq,
    StDone
  } state_e;

  localparam logic [1:0] ModeHalf = 2'b01;
  localparam logic [1:0] ModeByte = 2'b10;

  state_e            state_q, state_d;
  logic [ADDR_W+1:0] addr_q, addr_d;   // byte address; [1:0] selects the lane
  logic [31:0]       wdata_q, wdata_d; // store data, then the merged word
  logic [1:0]        mode_q, mode_d;
  logic              write_q, write_d;
  logic [31:0]       rdata_q, rdata_d;

  logic              accept;
  logic              acc_word;         // the request being accepted is a word access
  logic              trap;
  logic [31:0]       merged;

  // Address bits above the memory's word-address range are not used.
  logic              unused_adr_hi;
  assign unused_adr_hi = ^Adr[31:ADDR_W+2];

  assign accept   = req_write | req_read;
  // A load is always a word access. A store is a word access for modes 00 and 11.
  assign acc_word = ~req_write | ((MemMode != ModeHalf) && (MemMode != ModeByte));

`ifdef MISALIGN_TRAP_EN
  logic misaligned_q, misaligned_d;

  assign trap = (acc_word && (Adr[1:0] != 2'b00)) ||
                (req_write && (MemMode == ModeHalf) && Adr[0]);

  always_comb begin
    misaligned_d = misaligned_q;
    if (state_q == StIdle && accept) begin
      misaligned_d = trap;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      misaligned_q <= 1'b0;
    end else begin
      misaligned_q <= misaligned_d;
    end
  end

  assign Misaligned = misaligned_q;
`else
  assign trap       = 1'b0;
  assign Misaligned = 1'b0;
`endif

  // Read-modify-write merge: the new lane replaces the matching bits of the
  // word just read, and every other bit keeps the value from memory.
  always_comb begin
    merged = mem_rdata;
    unique case (mode_q)
      ModeByte: merged[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
      ModeHalf: merged[{addr_q[1], 4'b0000} +: 16]  = wdata_q[15:0];
      default:  merged = mem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mode_d  = mode_q;
    write_d = write_q;
    rdata_d = rdata_q;

    unique case (state_q)
      StIdle: begin
        // If both requests are high, the write wins and the read is dropped.
        if (accept) begin
          addr_d  = Adr[ADDR_W+1:0];
          wdata_d = WriteData;
          mode_d  = req_write ? MemMode : 2'b00;
          write_d = req_write;
          if (trap) begin
            state_d = StDone;
          end else if (req_write && acc_word) begin
            state_d = StWrReq;
          end else begin
            state_d = StRdReq;
          end
        end
      end
      StRdReq: begin
        if (mem_gnt) begin
          state_d = StRdWait;
        end
      end
      StRdWait: begin
        if (mem_rvalid) begin
          if (write_q) begin
            wdata_d = merged;
            state_d = StWrReq;
          end else begin
            rdata_d = mem_rdata >> {addr_q[1:0], 3'b000};
            state_d = StDone;
          end
        end
      end
      StWrReq: begin
        if (mem_gnt) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      mode_q  <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mode_q  <= mode_d;
      write_q <= write_d;
      rdata_q <= rdata_d;
    end
  end

  // These outputs are decoded from registers only. That keeps mem_addr and
  // mem_wdata stable while a request is held, and lets mem_req fall as soon
  // as reset is asserted.
  assign Busy      = (state_q != StIdle);
  assign Done      = (state_q == StDone);
  assign mem_req   = (state_q == StRdReq) || (state_q == StWrReq);
  assign mem_we    = (state_q == StWrReq);
  assign mem_addr  = addr_q[ADDR_W+1:2];
  assign mem_wdata = wdata_q;
  assign ReadData  = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  localparam int unsigned ADDR_W = 16;

`ifdef MISALIGN_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              req_read, req_write;
  logic [1:0]        MemMode;
  logic [31:0]       Adr, WriteData, ReadData;
  logic              Busy, Done, Misaligned;
  logic              mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata, mem_rdata;

  mem_access_unit #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .req_read(req_read), .req_write(req_write),
    .MemMode(MemMode), .Adr(Adr), .WriteData(WriteData), .ReadData(ReadData),
    .Busy(Busy), .Done(Done), .Misaligned(Misaligned), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Memory responder settings and state
  int          gnt_delay = 0;
  int          rv_delay  = 1;
  logic [31:0] init_word = 32'h0;
  int          req_wait  = 0;
  int          rv_timer  = 0;
  logic [31:0] rd_word   = 32'h0;
  int          wr_count  = 0;
  int          rd_count  = 0;
  logic [ADDR_W-1:0] held_addr;
  logic [31:0]       held_wdata;
  logic [31:0]       last_rdata = 32'h0;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;
  wr_t exp_wr_q[$];

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [1:0]  mode;
    logic [31:0] adr;
    logic [31:0] wd;
    logic [31:0] init;
    int          g;
    int          r;
    logic        misal;
    logic [31:0] exp_wr;
    int          lat;
    logic [31:0] exp_rd;
  } vec_t;
  vec_t vq[$];

  assign mem_gnt    = mem_req && (req_wait >= gnt_delay);
  assign mem_rvalid = (rv_timer == 1);
  assign mem_rdata  = rd_word;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory model: each read returns init_word rv_delay cycles after the grant.
  always @(posedge clk) begin
    if (mem_req && !mem_gnt) req_wait <= req_wait + 1;
    else                     req_wait <= 0;
    if (mem_req && !mem_we && mem_gnt) begin
      rd_word  <= init_word;
      rv_timer <= rv_delay;
    end else if (rv_timer > 0) begin
      rv_timer <= rv_timer - 1;
    end
  end

  // Request monitor: checks request stability and compares each write with the scoreboard.
  always @(negedge clk) begin
    wr_t e;
    if (!reset && mem_req) begin
      if (req_wait > 0) begin
        check("mem_addr_stable", 32'(mem_addr), 32'(held_addr));
        check("mem_wdata_stable", mem_wdata, held_wdata);
      end
      held_addr  = mem_addr;
      held_wdata = mem_wdata;
      if (mem_gnt && mem_we) begin
        wr_count++;
        if (exp_wr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%08h, no write expected",
                   mem_addr, mem_wdata);
        end else begin
          e = exp_wr_q.pop_front();
          check("wr_addr", 32'(mem_addr), 32'(e.addr));
          check("wr_data", mem_wdata, e.data);
        end
      end
      if (mem_gnt && !mem_we) rd_count++;
    end
  end

  task automatic add(input string name, input logic rd, input logic wr, input logic [1:0] mode,
                     input logic [31:0] adr, input logic [31:0] wd, input logic [31:0] init,
                     input int g, input int r, input logic misal, input logic [31:0] exp_wr,
                     input int lat, input logic [31:0] exp_rd);
    vec_t v;
    v.name = name; v.rd = rd; v.wr = wr; v.mode = mode; v.adr = adr; v.wd = wd;
    v.init = init; v.g = g; v.r = r; v.misal = misal; v.exp_wr = exp_wr;
    v.lat = lat; v.exp_rd = exp_rd;
    vq.push_back(v);
  endtask

  task automatic run_op(input vec_t v);
    int   cyc;
    logic trap;
    trap      = TrapEn && v.misal;
    gnt_delay = v.g;
    rv_delay  = v.r;
    init_word = v.init;
    if (v.wr && !trap) exp_wr_q.push_back('{addr: v.adr[ADDR_W+1:2], data: v.exp_wr});
    check({v.name, "_idle_busy"}, 32'(Busy), 32'd0);
    req_read  = v.rd;
    req_write = v.wr;
    MemMode   = v.mode;
    Adr       = v.adr;
    WriteData = v.wd;
    @(negedge clk);
    // Scramble the inputs after accept so that the DUT must use latched values.
    req_read  = 1'b0;
    req_write = 1'b0;
    Adr       = $urandom;
    WriteData = $urandom;
    MemMode   = 2'($urandom_range(0, 3));
    cyc = 1;
    while (!Done && cyc < 64) begin
      check({v.name, "_busy"}, 32'(Busy), 32'd1);
      @(negedge clk);
      cyc++;
    end
    if (!Done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: no Done after %0d cycles, expected one at %0d", v.name, cyc,
               v.lat);
    end else begin
      check({v.name, "_latency"}, 32'(cyc), trap ? 32'd1 : 32'(v.lat));
      check({v.name, "_busy_done"}, 32'(Busy), 32'd1);
      check({v.name, "_misaligned"}, 32'(Misaligned), 32'(trap));
      if (v.rd && !v.wr && !trap) last_rdata = v.exp_rd;
      check({v.name, "_rdata"}, ReadData, last_rdata);
    end
    @(negedge clk);
    check({v.name, "_done_pulse"}, 32'(Done), 32'd0);
    check({v.name, "_idle_after"}, 32'(Busy), 32'd0);
  endtask

  initial begin
    int   wr_before, rd_before, cyc;
    logic seen;
    vec_t v;

    //   name            rd wr mode   adr           wd            init          g  r  mis exp_wr        lat exp_rd
    add("sw_word",     0, 1, 2'b00, 32'h10,       32'hDEADBEEF, 32'h11223344, 0, 1, 0, 32'hDEADBEEF, 2,  0);
    add("sb_12",       0, 1, 2'b10, 32'h12,       32'h000000AB, 32'h11223344, 0, 1, 0, 32'h11AB3344, 4,  0);
    add("sh_12_gdly",  0, 1, 2'b01, 32'h12,       32'h0000CAFE, 32'h11223344, 3, 1, 0, 32'hCAFE3344, 10, 0);
    add("lw_13_rdly",  1, 0, 2'b00, 32'h13,       32'h0,        32'h80FF0102, 0, 2, 1, 32'h0,        4,  32'h00000080);
    add("lw_10",       1, 0, 2'b00, 32'h10,       32'h0,        32'h80FF0102, 0, 1, 0, 32'h0,        3,  32'h80FF0102);
    add("lw_11",       1, 0, 2'b00, 32'h11,       32'h0,        32'h80FF0102, 0, 1, 1, 32'h0,        3,  32'h0080FF01);
    add("lw_12_dly",   1, 0, 2'b00, 32'h12,       32'h0,        32'h80FF0102, 2, 3, 1, 32'h0,        7,  32'h000080FF);
    add("sb_14",       0, 1, 2'b10, 32'h14,       32'h00000055, 32'h00000000, 0, 1, 0, 32'h00000055, 4,  0);
    add("sb_17_gdly",  0, 1, 2'b10, 32'h17,       32'h123456CD, 32'hFFFFFFFF, 1, 1, 0, 32'hCDFFFFFF, 6,  0);
    add("sb_11",       0, 1, 2'b10, 32'h11,       32'h000000EE, 32'h11223344, 0, 1, 0, 32'h1122EE44, 4,  0);
    add("sh_14",       0, 1, 2'b01, 32'h14,       32'hBEEF1234, 32'hAAAAAAAA, 0, 1, 0, 32'hAAAA1234, 4,  0);
    add("sh_10_rdly",  0, 1, 2'b01, 32'h10,       32'hFFFF9999, 32'h11223344, 0, 2, 0, 32'h11229999, 5,  0);
    add("sh_13",       0, 1, 2'b01, 32'h13,       32'h00005678, 32'h00000000, 0, 1, 1, 32'h56780000, 4,  0);
    add("sw_mode3",    0, 1, 2'b11, 32'h20,       32'h01234567, 32'hFFFFFFFF, 0, 1, 0, 32'h01234567, 2,  0);
    add("sw_11",       0, 1, 2'b00, 32'h11,       32'hCAFEF00D, 32'h00000000, 0, 1, 1, 32'hCAFEF00D, 2,  0);
    add("sw_hi_adr",   0, 1, 2'b00, 32'hFFFC0040, 32'h13572468, 32'h00000000, 0, 1, 0, 32'h13572468, 2,  0);
    add("rw_both",     1, 1, 2'b00, 32'h30,       32'h0BADF00D, 32'h00000000, 0, 1, 0, 32'h0BADF00D, 2,  0);

    reset = 1'b1; req_read = 1'b0; req_write = 1'b0; MemMode = 2'b00;
    Adr = 32'h0; WriteData = 32'h0;
    #1;
    check("rst_readdata", ReadData, 32'h0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_misaligned", 32'(Misaligned), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      rd_before = rd_count;
      run_op(v);
      if (v.rd && v.wr) check("rw_both_no_read", 32'(rd_count), 32'(rd_before));
    end

    // A store request while a load is in flight is ignored.
    gnt_delay = 0; rv_delay = 3; init_word = 32'h80FF0102;
    wr_before = wr_count;
    req_read = 1'b1; Adr = 32'h10;
    @(negedge clk);
    req_read = 1'b0; req_write = 1'b1; MemMode = 2'b00; Adr = 32'h20; WriteData = 32'h55555555;
    @(negedge clk);
    @(negedge clk);
    req_write = 1'b0;
    cyc = 3;
    while (!Done && cyc < 64) begin
      @(negedge clk);
      cyc++;
    end
    check("busy_ignore_lat", 32'(cyc), 32'd5);
    last_rdata = 32'h80FF0102;
    check("busy_ignore_rdata", ReadData, last_rdata);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (Done) seen = 1'b1;
    end
    check("busy_ignore_no_write", 32'(wr_count), 32'(wr_before));
    check("busy_ignore_no_done", 32'(seen), 32'd0);

    // Reset while waiting for read data: everything clears at once, and the late rvalid is ignored.
    gnt_delay = 0; rv_delay = 3; init_word = 32'h12345678;
    req_read = 1'b1; Adr = 32'h18;
    @(negedge clk);
    req_read = 1'b0;
    @(negedge clk);
    check("rdwait_busy", 32'(Busy), 32'd1);
    reset = 1'b1;
    #1;
    check("midrst_readdata", ReadData, 32'h0);
    check("midrst_busy", 32'(Busy), 32'd0);
    check("midrst_done", 32'(Done), 32'd0);
    check("midrst_mem_req", 32'(mem_req), 32'd0);
    check("midrst_mem_addr", 32'(mem_addr), 32'd0);
    last_rdata = 32'h0;
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (Done || Busy) seen = 1'b1;
    end
    check("late_rvalid_ignored", 32'(seen), 32'd0);
    check("late_rvalid_rdata", ReadData, 32'h0);

    // Reset while a request is held: mem_req falls without waiting for a clock edge.
    gnt_delay = 5;
    req_write = 1'b1; MemMode = 2'b00; Adr = 32'h40; WriteData = 32'h77777777;
    @(negedge clk);
    req_write = 1'b0;
    @(negedge clk);
    check("held_req_high", 32'(mem_req), 32'd1);
    reset = 1'b1;
    #1;
    check("async_req_drop", 32'(mem_req), 32'd0);
    check("async_we_drop", 32'(mem_we), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    gnt_delay = 0;
    repeat (2) @(negedge clk);

    check("wr_queue_drained", 32'(exp_wr_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
